instr_fetch_unit: RTL and testbench

Sequential instruction-fetch front end for the MIPS datapath; it produces the instruction stream that the controller decodes. It holds the PC and fetches words from instruction memory over a req/ack handshake. It presents the current instruction with its `opc`/`func` fields and waits for the execute side to consume it. On consume it takes the controller's `PCSrc` and computes the next PC, covering sequential, branch, jump and jump-register paths.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Sequential instruction-fetch front end. Holds the PC, fetches one word at a
//   time from instruction memory over a req/ack handshake, presents it with its
//   opc/func fields, and on `advance` computes the next PC from PCSrc
//   (sequential, branch, jump, jump-register). A misaligned jr target halts the
//   unit until reset.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   PCSrc[1:0]    : next-PC select (00 +4, 01 branch, 10 jump, 11 rs_data)
//   rs_data[31:0] : jr target
//   advance       : execute side consumed the current instruction
//   imem_req/addr : fetch request and byte address (addr == pc)
//   imem_ack/rdata: fetch completion and returned word
//   instr, opc, func, instr_valid : current instruction and its fields
//   pc, pc_plus4  : address of current/pending instruction and pc+4
//   misalign_err  : sticky jr misalignment flag
//   instr_count   : number of accepted advances (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] rs_data,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opc,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        jr_misalign;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign opc       = instr[31:26];
  assign func      = instr[5:0];

  assign jr_misalign = (PCSrc == 2'b11) && (rs_data[1:0] != 2'b00);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    next_pc = pc_plus4;
    br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    unique case (PCSrc)
      2'b00: next_pc = pc_plus4;
      2'b01: next_pc = pc_plus4 + br_off;
      2'b10: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11: next_pc = rs_data;
      default: next_pc = pc_plus4;
    endcase
  end

  // imem_req and instr_valid are registered and reset asynchronously, so a
  // reset mid-fetch drops the request immediately; a late ack lands in IDLE
  // and is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= 32'd0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      instr_count  <= 32'd0;
      imem_req     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // sees pre-edge values regardless of statement order.
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            instr_count <= instr_count + 32'd1;
            instr_valid <= 1'b0;
            if (jr_misalign) begin
              // pc keeps the address of the offending jr for debug.
              misalign_err <= 1'b1;
              state        <= ERR;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        ERR: begin
          // Halted: no requests, all inputs ignored until reset.
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Scoreboard bench for instr_fetch_unit. Expected fetch addresses are pushed
//   when an advance is driven and popped when the DUT raises a request; expected
//   instruction words are pushed when the memory model acks and popped when
//   instr_valid rises. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] rs_data = 32'd0;
  logic        advance = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opc;
  logic [5:0]  func;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] addr_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_instr;
  logic [31:0] model_count;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .rs_data(rs_data), .advance(advance),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .opc(opc), .func(func),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_err(misalign_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a few hand-placed control-flow words, a hash
  // elsewhere so opc/func differ from word to word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h1000_FFFE;  // branch, offset -2
      32'h0000_00FC: return 32'h1000_0004;  // branch, offset +4
      32'h9000_0010: return 32'h0800_0040;  // jump, target field 0x40
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic [1:0] src, input logic [31:0] rs);
    logic [31:0] p4;
    p4 = p + 32'd4;
    case (src)
      2'b00:   return p4;
      2'b01:   return p4 + ({{16{ins[15]}}, ins[15:0]} << 2);
      2'b10:   return {p4[31:28], ins[25:0], 2'b00};
      default: return rs;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_pc"},    pc, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check({tag, "_count"}, instr_count, 32'd0);
    check({tag, "_err"},   {31'd0, misalign_err}, 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    advance = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_opc", {26'd0, opc}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_pc = 32'h0;
    model_count = 32'd0;
    addr_q.delete();
    instr_q.delete();
    addr_q.push_back(32'h0);
  endtask

  // Serve one fetch with `waits` cycles of ack delay; with `noise` set,
  // advance and PCSrc toggle during the wait cycles and must be ignored.
  task automatic fetch_one(input int waits, input bit noise);
    int n;
    logic [31:0] a;
    logic [31:0] e;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    a = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
    check("fetch_addr", imem_addr, a);
    check("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < waits; k++) begin
      imem_ack = 1'b0;
      advance  = noise;
      PCSrc    = noise ? 2'($urandom_range(3)) : 2'b00;
      @(negedge clk);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, a);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    advance    = 1'b0;
    PCSrc      = 2'b00;
    imem_ack   = 1'b1;
    imem_rdata = mem_word(a);
    instr_q.push_back(mem_word(a));
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    e = (instr_q.size() != 0) ? instr_q.pop_front() : 32'hDEAD_BEEF;
    check("valid_rise", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, e);
    check("opc", {26'd0, opc}, {26'd0, e[31:26]});
    check("func", {26'd0, func}, {26'd0, e[5:0]});
    check("req_drop", {31'd0, imem_req}, 32'd0);
    check("count_hold", instr_count, model_count);
    check("pc_plus4", pc_plus4, a + 32'd4);
    model_instr = e;
  endtask

  task automatic do_advance(input logic [1:0] src, input logic [31:0] rs);
    logic [31:0] nxt;
    bit mis;
    mis = (src == 2'b11) && (rs[1:0] != 2'b00);
    nxt = model_next(model_pc, model_instr, src, rs);
    PCSrc   = src;
    rs_data = rs;
    advance = 1'b1;
    @(negedge clk);
    advance = 1'b0;
    model_count = model_count + 32'd1;
    check("adv_valid", {31'd0, instr_valid}, 32'd0);
    check("adv_count", instr_count, model_count);
    if (mis) begin
      check("mis_err", {31'd0, misalign_err}, 32'd1);
      check("mis_pc", pc, model_pc);
      check("mis_req", {31'd0, imem_req}, 32'd0);
    end else begin
      model_pc = nxt;
      addr_q.push_back(nxt);
      check("adv_pc", pc, nxt);
      check("adv_req", {31'd0, imem_req}, 32'd1);
      check("adv_err", {31'd0, misalign_err}, 32'd0);
    end
  endtask

  initial begin
    model_pc = 32'h0;
    model_instr = 32'h0;
    model_count = 32'd0;
    apply_reset();

    // Sequential: addresses 0,4,8,C then count 4.
    for (int i = 0; i < 4; i++) begin
      fetch_one(0, 1'b0);
      do_advance(2'b00, 32'd0);
    end
    check("seq_count4", instr_count, 32'd4);
    check("seq_pc", pc, 32'h10);

    // Branches from 0x100: -2 words to 0xFC, then +4 words to 0x110.
    fetch_one(0, 1'b0);
    do_advance(2'b11, 32'h0000_0100);
    fetch_one(0, 1'b0);
    do_advance(2'b01, 32'hFFFF_FFFF);
    check("br_neg_pc", pc, 32'h0000_00FC);
    fetch_one(0, 1'b0);
    do_advance(2'b01, 32'd0);
    check("br_pos_pc", pc, 32'h0000_0110);

    // Jump keeps the upper nibble of pc+4; then an aligned jr.
    fetch_one(0, 1'b0);
    do_advance(2'b11, 32'h9000_0010);
    fetch_one(0, 1'b0);
    do_advance(2'b10, 32'd0);
    check("jump_pc", pc, 32'h9000_0100);
    fetch_one(0, 1'b0);
    do_advance(2'b11, 32'h0000_2000);
    check("jr_pc", pc, 32'h0000_2000);

    // Three wait states with advance noise while fetching.
    fetch_one(3, 1'b1);
    do_advance(2'b00, 32'd0);
    fetch_one(1, 1'b1);

    // Misaligned jr halts until reset.
    do_advance(2'b11, 32'h0000_2002);
    for (int i = 0; i < 8; i++) begin
      advance  = 1'b1;
      imem_ack = 1'b1;
      PCSrc    = 2'($urandom_range(3));
      @(negedge clk);
      check("err_req", {31'd0, imem_req}, 32'd0);
      check("err_sticky", {31'd0, misalign_err}, 32'd1);
      check("err_count", instr_count, model_count);
    end
    advance  = 1'b0;
    imem_ack = 1'b0;
    apply_reset();
    fetch_one(0, 1'b0);
    do_advance(2'b00, 32'd0);
    fetch_one(0, 1'b0);
    do_advance(2'b00, 32'd0);

    // Reset during an un-acked request, stale ack one cycle after release.
    check("pre_mid_req", {31'd0, imem_req}, 32'd1);
    check("pre_mid_count", instr_count, 32'd2);
    #2 rst = 1'b1;
    #1 check_reset_values("mid");
    @(negedge clk);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    imem_ack = 1'b0;
    check("stale_instr", instr, 32'h0);
    check("stale_valid", {31'd0, instr_valid}, 32'd0);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    model_pc = 32'h0;
    model_count = 32'd0;
    addr_q.delete();
    instr_q.delete();
    addr_q.push_back(32'h0);
    fetch_one(0, 1'b0);
    do_advance(2'b00, 32'd0);
    check("final_count", instr_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
